axi_burst_splitter: RTL and testbench

AXI_BURST_SPLITTER -- requirements
Module: axi_burst_splitter

---
 rtl/axi_pkg.sv | 19 +
 rtl/axi_burst_splitter_if.sv | 41 ++++
 rtl/axi_burst_calc.sv | 36 +++
 rtl/axi_burst_splitter.sv | 96 +++++++++
 tb/tb_axi_burst_splitter.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/axi_pkg.sv
// Shared AXI definitions for the burst splitter: FSM state type, response codes
// and the 4KB address-boundary constant.
package axi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  localparam int unsigned BOUNDARY_4K = 4096;

endpackage

// File: rtl/axi_burst_splitter_if.sv
// Bus bundle for the burst splitter: request in, sub-burst commands out,
// sub-burst completions in and the transfer-complete pulse out.
interface axi_burst_splitter_if #(
  parameter int ADDR_WIDTH = 32
);
  // Handshakes: a transfer happens on the clock edge where valid && ready;
  // valid and its payload stay stable until then, and ready may not wait on valid.
  // sub_resp_valid and done_valid are single-cycle pulses with no back-pressure.
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [15:0]           req_len;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [7:0]            cmd_len;

  logic                  sub_resp_valid;
  logic [1:0]            sub_resp;

  logic                  done_valid;
  logic [1:0]            done_resp;

  modport slave (
    input  req_valid, req_write, req_addr, req_len,
    input  cmd_ready, sub_resp_valid, sub_resp,
    output req_ready, cmd_valid, cmd_write, cmd_addr, cmd_len,
    output done_valid, done_resp
  );

  modport master (
    output req_valid, req_write, req_addr, req_len,
    output cmd_ready, sub_resp_valid, sub_resp,
    input  req_ready, cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  done_valid, done_resp
  );

endinterface

// File: rtl/axi_burst_calc.sv
// Combinational sizing of the next sub-burst from the current address and remaining beats.
// Macro AXI_SPLIT_4K_EN additionally stops each burst at the next 4KB boundary.
module axi_burst_calc
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BEATS  = 256
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [16:0]           remaining,
  output logic [8:0]            burst
);

  localparam int SHIFT = $clog2(DATA_WIDTH / 8);

  logic [16:0] capped;
  logic        unused_addr;

  assign unused_addr = ^addr;

`ifdef AXI_SPLIT_4K_EN
  logic [12:0] to_bound;
`endif

  always_comb begin
    capped = (remaining > 17'(MAX_BEATS)) ? 17'(MAX_BEATS) : remaining;
`ifdef AXI_SPLIT_4K_EN
    // addr is beat-aligned, so the division by BPB is exact
    to_bound = (13'(BOUNDARY_4K) - {1'b0, addr[11:0]}) >> SHIFT;
    if (17'(to_bound) < capped) capped = 17'(to_bound);
`endif
    burst = capped[8:0];
  end

endmodule

// File: rtl/axi_burst_splitter.sv
// Splits one long AXI transfer request into MAX_BEATS-capped sub-bursts and reports
// the worst sub-burst response. Optional 4KB splitting: macro AXI_SPLIT_4K_EN.
module axi_burst_splitter
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BEATS  = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  axi_burst_splitter_if.slave    bus,
  output state_t                 state
);

  localparam int SHIFT = $clog2(DATA_WIDTH / 8);

  state_t                state_d;
  logic                  req_ready_q;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [16:0]           rem_q;
  logic [16:0]           outstanding_q;
  logic [16:0]           outstanding_d;
  logic [1:0]            acc_q;
  logic [8:0]            burst;
  logic                  req_hs;
  logic                  cmd_hs;
  logic                  resp_counted;

  axi_burst_calc #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_BEATS  (MAX_BEATS)
  ) u_calc (
    .addr      (addr_q),
    .remaining (rem_q),
    .burst     (burst)
  );

  always_comb begin
    req_hs        = bus.req_valid && req_ready_q;
    cmd_hs        = (state == ISSUE) && bus.cmd_ready;
    resp_counted  = bus.sub_resp_valid && (outstanding_q != 17'd0);
    outstanding_d = outstanding_q;
    if (cmd_hs && !resp_counted)      outstanding_d = outstanding_q + 17'd1;
    else if (!cmd_hs && resp_counted) outstanding_d = outstanding_q - 17'd1;

    state_d = state;
    case (state)
      IDLE:    if (req_hs) state_d = ISSUE;
      ISSUE:   if (cmd_hs && (rem_q == 17'(burst))) state_d = DRAIN;
      DRAIN:   if (outstanding_d == 17'd0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command payload comes straight from registered address/remaining, so it is stable while stalled
  assign bus.req_ready  = req_ready_q;
  assign bus.cmd_valid  = (state == ISSUE);
  assign bus.cmd_write  = (state == ISSUE) && write_q;
  assign bus.cmd_addr   = (state == ISSUE) ? addr_q : '0;
  assign bus.cmd_len    = (state == ISSUE) ? 8'(burst - 9'd1) : 8'd0;
  assign bus.done_valid = (state == DONE);
  assign bus.done_resp  = (state == DONE) ? acc_q : 2'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      req_ready_q   <= 1'b0;
      write_q       <= 1'b0;
      addr_q        <= '0;
      rem_q         <= 17'd0;
      outstanding_q <= 17'd0;
      acc_q         <= 2'd0;
    end else begin
      state         <= state_d;
      req_ready_q   <= (state_d == IDLE);
      outstanding_q <= outstanding_d;
      if (req_hs) begin
        write_q <= bus.req_write;
        addr_q  <= bus.req_addr & ~ADDR_WIDTH'(DATA_WIDTH / 8 - 1);
        rem_q   <= {1'b0, bus.req_len} + 17'd1;
        acc_q   <= 2'd0;
      end else begin
        if (cmd_hs) begin
          addr_q <= addr_q + (ADDR_WIDTH'(burst) << SHIFT);
          rem_q  <= rem_q - 17'(burst);
        end
        if (resp_counted && (bus.sub_resp > acc_q)) acc_q <= bus.sub_resp;
      end
    end
  end

endmodule

// File: tb/tb_axi_burst_splitter.sv
// Randomized bench for axi_burst_splitter: a transfer-level model predicts every
// sub-burst command and the final worst response; honours AXI_SPLIT_4K_EN.
module tb_axi_burst_splitter;
  import axi_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MB  = 256;
  localparam int BPB = DW / 8;
  localparam int EW  = 1 + AW + 8;

  logic   clk = 1'b0;
  logic   rst;
  state_t state;

  always #5 clk = ~clk;

  axi_burst_splitter_if #(.ADDR_WIDTH(AW)) bus ();

  axi_burst_splitter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MAX_BEATS  (MB)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .state (state)
  );

  int            tests_run    = 0;
  int            tests_failed = 0;
  logic [EW-1:0] exp_q[$];
  logic [1:0]    forced_q[$];
  int            pending;
  logic [1:0]    exp_acc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Transfer-level model: walk the request in beats, cutting at MAX_BEATS (and 4KB)
  task automatic build_expected(input logic wr, input logic [AW-1:0] addr, input int len);
    logic [AW-1:0] a;
    int            rem;
    int            b;
    a   = addr & ~AW'(BPB - 1);
    rem = len + 1;
    while (rem > 0) begin
      b = (rem < MB) ? rem : MB;
`ifdef AXI_SPLIT_4K_EN
      if ((4096 - int'(a[11:0])) / BPB < b) b = (4096 - int'(a[11:0])) / BPB;
`endif
      exp_q.push_back({wr, a, 8'(b - 1)});
      a   = a + AW'(b * BPB);
      rem = rem - b;
    end
  endtask

  task automatic idle_inputs();
    bus.req_valid      = 1'b0;
    bus.req_write      = 1'b0;
    bus.req_addr       = '0;
    bus.req_len        = 16'd0;
    bus.cmd_ready      = 1'b0;
    bus.sub_resp_valid = 1'b0;
    bus.sub_resp       = 2'd0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_cmd_valid"},  bus.cmd_valid, 0);
    check({tag, "_cmd_addr"},   bus.cmd_addr, 0);
    check({tag, "_cmd_len"},    bus.cmd_len, 0);
    check({tag, "_cmd_write"},  bus.cmd_write, 0);
    check({tag, "_done_valid"}, bus.done_valid, 0);
    check({tag, "_done_resp"},  bus.done_resp, 0);
    check({tag, "_req_ready"},  bus.req_ready, 0);
    check({tag, "_state"},      state, IDLE);
  endtask

  task automatic send_req(input logic wr, input logic [AW-1:0] addr, input int len);
    check("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_len   = 16'(len);
    exp_q.delete();
    build_expected(wr, addr, len);
    exp_acc = RESP_OKAY;
    pending = 0;
    @(negedge clk);
    idle_inputs();
    check("req_ready_busy", bus.req_ready, 0);
  endtask

  task automatic run_transfer(input logic wr, input logic [AW-1:0] addr, input int len,
                              input int stall, input int ready_pct);
    logic [EW-1:0] head;
    int            cyc;
    bit            done;
    send_req(wr, addr, len);
    for (int i = 0; i < stall; i++) begin
      bus.cmd_ready = 1'b0;
      head = exp_q[0];
      check("stall_valid",     bus.cmd_valid, 1);
      check("stall_addr",      bus.cmd_addr, head[8 +: AW]);
      check("stall_len",       bus.cmd_len, head[7:0]);
      check("stall_req_ready", bus.req_ready, 0);
      @(negedge clk);
    end
    done = 1'b0;
    cyc  = 0;
    while (!done && cyc < 4000) begin
      if (bus.done_valid) begin
        idle_inputs();
        check("done_resp",  bus.done_resp, exp_acc);
        check("cmds_left",  exp_q.size(), 0);
        check("resps_left", pending, 0);
        done = 1'b1;
      end else begin
        check("cmd_valid", bus.cmd_valid, exp_q.size() != 0);
        if (pending > 0 && $urandom_range(0, 99) < 50) begin
          bus.sub_resp_valid = 1'b1;
          bus.sub_resp = (forced_q.size() != 0) ? forced_q.pop_front() : 2'($urandom_range(0, 3));
          if (bus.sub_resp > exp_acc) exp_acc = bus.sub_resp;
          pending--;
        end else begin
          bus.sub_resp_valid = 1'b0;
          bus.sub_resp       = 2'($urandom_range(0, 3));
        end
        bus.cmd_ready = ($urandom_range(0, 99) < ready_pct);
        if (bus.cmd_valid && bus.cmd_ready) begin
          if (exp_q.size() == 0) begin
            check("cmd_unexpected", bus.cmd_valid, 0);
          end else begin
            head = exp_q.pop_front();
            check("cmd_write", bus.cmd_write, head[EW-1]);
            check("cmd_addr",  bus.cmd_addr, head[8 +: AW]);
            check("cmd_len",   bus.cmd_len, head[7:0]);
            pending++;
          end
        end
        @(negedge clk);
        cyc++;
      end
    end
    if (!done) begin
      idle_inputs();
      check("done_timeout", done, 1);
    end
    @(negedge clk);
    check("done_pulse",     bus.done_valid, 0);
    check("done_resp_idle", bus.done_resp, 0);
    check("req_ready_back", bus.req_ready, 1);
    check("state_idle",     state, IDLE);
  endtask

  task automatic reset_mid_transfer();
    send_req(1'b0, 32'h0000_2000, 1023);
    bus.cmd_ready = 1'b1;
    check("rst_first_cmd", bus.cmd_addr, 32'h0000_2000);
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    #1;
    check_outputs_zero("rst_async");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_no_done", bus.done_valid, 0);
    end
    rst = 1'b0;
    #1;
    check("rst_release_ready", bus.req_ready, 0);
    @(negedge clk);
    check("rst_ready_rises", bus.req_ready, 1);
    exp_q.delete();
    pending = 0;
  endtask

  initial begin
    logic [AW-1:0] ra;
    idle_inputs();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_outputs_zero("reset");
    end
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", bus.req_ready, 1);

    // Stray completion with nothing outstanding must be ignored
    bus.sub_resp_valid = 1'b1;
    bus.sub_resp       = RESP_DECERR;
    @(negedge clk);
    idle_inputs();
    check("stray_resp_state", state, IDLE);

    forced_q = '{RESP_OKAY};
    run_transfer(1'b1, 32'h0000_1000, 9, 0, 100);
    forced_q = '{RESP_OKAY, RESP_OKAY, RESP_OKAY};
    run_transfer(1'b0, 32'h0000_0000, 599, 0, 100);
    forced_q = '{RESP_OKAY, RESP_OKAY};
    run_transfer(1'b0, 32'h0000_0FF0, 7, 0, 100);
    forced_q = '{RESP_OKAY, RESP_SLVERR, RESP_OKAY};
    run_transfer(1'b1, 32'h0000_0000, 767, 0, 100);
    run_transfer(1'b1, 32'h0000_3000, 300, 5, 100);

    reset_mid_transfer();
    forced_q = '{RESP_EXOKAY};
    run_transfer(1'b0, 32'h0000_1000, 9, 0, 100);

    forced_q.delete();
    run_transfer(1'b0, 32'hFFFF_FF00, 600, 0, 70);
    run_transfer(1'b1, 32'h0000_0123, 65535, 0, 90);
    run_transfer(1'b0, 32'h0000_0002, 0, 0, 50);

    for (int t = 0; t < 30; t++) begin
      ra = $urandom;
      if ($urandom_range(0, 1) == 1) ra[11:0] = 12'(4096 - 4 * $urandom_range(1, 40));
      run_transfer(1'($urandom_range(0, 1)), ra, $urandom_range(0, 1200), $urandom_range(0, 2),
                   $urandom_range(30, 100));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
